// File: rtl/adc_fifo_rd_ctrl_if.sv
// Signal bundle between the ADC FIFO read controller and its FIFO / algorithm neighbours.
// The master side is the controller; the slave side is the FIFO plus the effects algorithm.
interface adc_fifo_rd_ctrl_if;
    logic        fifo_empty;
    logic        fifo_almost_full;
    logic [31:0] fifo_q;
    logic        fifo_rd_en;
    logic        sample_ready;
    logic        sample_valid;
    logic [31:0] sample_left;
    logic [31:0] sample_right;
    logic [15:0] overrun_cnt;
    logic        underrun;
    logic        clr_status;

    modport master (
        input  fifo_empty, fifo_almost_full, fifo_q, sample_ready, clr_status,
        output fifo_rd_en, sample_valid, sample_left, sample_right, overrun_cnt, underrun
    );

    modport slave (
        output fifo_empty, fifo_almost_full, fifo_q, sample_ready, clr_status,
        input  fifo_rd_en, sample_valid, sample_left, sample_right, overrun_cnt, underrun
    );
endinterface

// File: rtl/adc_fifo_rd_ctrl.sv
// Read-side sequencer for the ADC dual-clock FIFO: pops I2S words, builds left/right
// frames, hands them to the algorithm over valid/ready and tracks overrun/underrun.
module adc_fifo_rd_ctrl #(
    parameter int RD_LATENCY   = 1,
    parameter bit STEREO       = 1'b1,
    parameter bit DROP_ON_FULL = 1'b1
) (
    input logic               alg_clk,
    input logic               resetn,
    adc_fifo_rd_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_L    = 3'd1,
        WAIT_L  = 3'd2,
        RD_R    = 3'd3,
        WAIT_R  = 3'd4,
        PRESENT = 3'd5
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

    state_t      state_reg, state_next;
    logic [1:0]  lat_cnt_reg, lat_cnt_next;
    logic [31:0] left_reg, left_next;
    logic [31:0] right_reg, right_next;
    logic [15:0] ovr_cnt_reg, ovr_cnt_next;
    logic        underrun_reg, underrun_next;
    logic        rd_en;
    logic        lat_done;
    logic        ovr_event;
    logic        unr_event;

    always_ff @(posedge alg_clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            lat_cnt_reg  <= 2'd0;
            left_reg     <= 32'd0;
            right_reg    <= 32'd0;
            ovr_cnt_reg  <= 16'd0;
            underrun_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lat_cnt_reg  <= lat_cnt_next;
            left_reg     <= left_next;
            right_reg    <= right_next;
            ovr_cnt_reg  <= ovr_cnt_next;
            underrun_reg <= underrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        lat_cnt_next = lat_cnt_reg;
        left_next    = left_reg;
        right_next   = right_reg;
        rd_en        = 1'b0;
        ovr_event    = 1'b0;
        unr_event    = 1'b0;
        lat_done     = (lat_cnt_reg == LAT_LAST);
        case (state_reg)
            IDLE: begin
                unr_event = bus.fifo_empty && bus.sample_ready;
                if (!bus.fifo_empty) state_next = RD_L;
            end
            RD_L: begin
                // Gated on empty as well, so a read can never be issued into an empty FIFO.
                if (!bus.fifo_empty) begin
                    rd_en        = 1'b1;
                    lat_cnt_next = 2'd0;
                    state_next   = WAIT_L;
                end
            end
            WAIT_L: begin
                if (lat_done) begin
                    left_next = bus.fifo_q;
                    if (STEREO) begin
                        state_next = RD_R;
                    end else begin
                        right_next = bus.fifo_q;
                        state_next = PRESENT;
                    end
                end else begin
                    lat_cnt_next = lat_cnt_reg + 2'd1;
                end
            end
            RD_R: begin
                if (!bus.fifo_empty) begin
                    rd_en        = 1'b1;
                    lat_cnt_next = 2'd0;
                    state_next   = WAIT_R;
                end
            end
            WAIT_R: begin
                if (lat_done) begin
                    right_next = bus.fifo_q;
                    state_next = PRESENT;
                end else begin
                    lat_cnt_next = lat_cnt_reg + 2'd1;
                end
            end
            PRESENT: begin
                // A completed handshake takes priority over an overrun drop.
                if (bus.sample_ready) begin
                    state_next = IDLE;
                end else if (DROP_ON_FULL && bus.fifo_almost_full) begin
                    ovr_event  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status: a same-cycle event beats clr_status.
    always_comb begin
        ovr_cnt_next  = ovr_cnt_reg;
        underrun_next = underrun_reg;
        if (ovr_event) begin
            if (bus.clr_status)              ovr_cnt_next = 16'd1;
            else if (ovr_cnt_reg != 16'hFFFF) ovr_cnt_next = ovr_cnt_reg + 16'd1;
        end else if (bus.clr_status) begin
            ovr_cnt_next = 16'd0;
        end
        if (unr_event)           underrun_next = 1'b1;
        else if (bus.clr_status) underrun_next = 1'b0;
    end

    assign bus.fifo_rd_en   = rd_en;
    assign bus.sample_valid = (state_reg == PRESENT);
    assign bus.sample_left  = left_reg;
    assign bus.sample_right = right_reg;
    assign bus.overrun_cnt  = ovr_cnt_reg;
    assign bus.underrun     = underrun_reg;
endmodule

// File: tb/tb_adc_fifo_rd_ctrl.sv
// Bench for adc_fifo_rd_ctrl: stereo and mono instances fed from simple FIFO models,
// a frame/overrun scoreboard checked every cycle, plus directed literal expectations.
module tb_adc_fifo_rd_ctrl;
    logic alg_clk = 1'b0;
    logic resetn  = 1'b0;
    always #5 alg_clk = ~alg_clk;

    adc_fifo_rd_ctrl_if st_if ();
    adc_fifo_rd_ctrl_if mo_if ();

    adc_fifo_rd_ctrl #(.RD_LATENCY(1), .STEREO(1'b1), .DROP_ON_FULL(1'b1)) u_st (
        .alg_clk (alg_clk),
        .resetn  (resetn),
        .bus     (st_if.master)
    );

    adc_fifo_rd_ctrl #(.RD_LATENCY(1), .STEREO(1'b0), .DROP_ON_FULL(1'b1)) u_mo (
        .alg_clk (alg_clk),
        .resetn  (resetn),
        .bus     (mo_if.master)
    );

    // FIFO models: one-cycle read latency, pointers never wrap within this run.
    logic [31:0] st_mem [0:63];
    logic [31:0] mo_mem [0:63];
    int st_wp = 0, st_rp = 0, mo_wp = 0, mo_rp = 0;
    assign st_if.fifo_empty = (st_wp == st_rp);
    assign mo_if.fifo_empty = (mo_wp == mo_rp);

    always @(posedge alg_clk) begin
        if (st_if.fifo_rd_en && st_wp != st_rp) begin
            st_if.fifo_q <= st_mem[st_rp % 64];
            st_rp        <= st_rp + 1;
        end
        if (mo_if.fifo_rd_en && mo_wp != mo_rp) begin
            mo_if.fifo_q <= mo_mem[mo_rp % 64];
            mo_rp        <= mo_rp + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge alg_clk);
        #1;
    endtask

    task automatic push_st(logic [31:0] w);
        st_mem[st_wp % 64] = w;
        st_wp++;
    endtask

    task automatic wait_valid(string name);
        int n = 0;
        while (!st_if.sample_valid && n < 30) begin
            tick();
            n++;
        end
        chk(name, 96'(st_if.sample_valid), 96'd1);
    endtask

    // Scoreboard: words leaving the FIFO pair up into frames in arrival order; a frame
    // retires on handshake or drop; drops are counted with clear/saturate rules.
    logic [63:0] exp_frames [$];
    logic [31:0] held_word;
    bit          have_left  = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_taken = 1'b0;
    int          exp_ovr    = 0;

    initial forever begin
        @(negedge alg_clk);
        if (!resetn) begin
            chk("reset_outputs",
                {st_if.fifo_rd_en, st_if.sample_valid, st_if.underrun, st_if.overrun_cnt,
                 st_if.sample_left, st_if.sample_right}, 96'd0);
            exp_frames.delete();
            have_left  = 1'b0;
            prev_valid = 1'b0;
            prev_taken = 1'b0;
            exp_ovr    = 0;
        end else begin
            bit taken;
            chk("rd_en_vs_empty", 96'(st_if.fifo_rd_en && st_if.fifo_empty), 96'd0);
            chk("overrun_model", 96'(st_if.overrun_cnt), 96'(exp_ovr));
            if (st_if.sample_valid) begin
                if (exp_frames.size() == 0) chk("frame_unexpected", 96'd1, 96'd0);
                else chk("frame_model", {st_if.sample_left, st_if.sample_right}, 96'(exp_frames[0]));
            end
            if (prev_valid && !prev_taken && !st_if.sample_valid)
                chk("valid_withdrawn", 96'd1, 96'd0);
            taken = st_if.sample_valid && (st_if.sample_ready || st_if.fifo_almost_full);
            if (st_if.sample_valid && !st_if.sample_ready && st_if.fifo_almost_full)
                exp_ovr = st_if.clr_status ? 1 : (exp_ovr < 65535 ? exp_ovr + 1 : exp_ovr);
            else if (st_if.clr_status)
                exp_ovr = 0;
            if (taken && exp_frames.size() > 0) void'(exp_frames.pop_front());
            if (st_if.fifo_rd_en && !st_if.fifo_empty) begin
                if (!have_left) begin
                    held_word = st_mem[st_rp % 64];
                    have_left = 1'b1;
                end else begin
                    exp_frames.push_back({held_word, st_mem[st_rp % 64]});
                    have_left = 1'b0;
                end
            end
            prev_valid = st_if.sample_valid;
            prev_taken = taken;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        st_if.fifo_almost_full = 1'b0;
        st_if.sample_ready     = 1'b0;
        st_if.clr_status       = 1'b0;
        mo_if.fifo_almost_full = 1'b0;
        mo_if.sample_ready     = 1'b0;
        mo_if.clr_status       = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        repeat (2) tick();

        // Stereo and mono latency, both starting in the same cycle 0.
        push_st(32'hAAAA0001);
        push_st(32'hBBBB0002);
        mo_mem[mo_wp % 64] = 32'h12345678;
        mo_wp++;
        st_if.sample_ready = 1'b1;
        mo_if.sample_ready = 1'b1;
        tick();
        chk("st_c1_rd_en", 96'(st_if.fifo_rd_en), 96'd1);
        chk("mo_c1_rd_en", 96'(mo_if.fifo_rd_en), 96'd1);
        tick();
        chk("st_c2_rd_en", 96'(st_if.fifo_rd_en), 96'd0);
        chk("mo_c2_valid", 96'(mo_if.sample_valid), 96'd0);
        tick();
        chk("st_c3_rd_en", 96'(st_if.fifo_rd_en), 96'd1);
        chk("mo_c3_valid", 96'(mo_if.sample_valid), 96'd1);
        chk("mo_c3_frame", {mo_if.sample_left, mo_if.sample_right}, {32'h12345678, 32'h12345678});
        tick();
        mo_if.sample_ready = 1'b0;
        chk("st_c4_valid", 96'(st_if.sample_valid), 96'd0);
        chk("mo_c4_valid", 96'(mo_if.sample_valid), 96'd0);
        tick();
        chk("st_c5_valid", 96'(st_if.sample_valid), 96'd1);
        chk("st_c5_frame", {st_if.sample_left, st_if.sample_right}, {32'hAAAA0001, 32'hBBBB0002});
        tick();
        st_if.sample_ready = 1'b0;
        chk("st_c6_valid", 96'(st_if.sample_valid), 96'd0);
        chk("st_c6_underrun", 96'(st_if.underrun), 96'd0);

        // Stall waiting for the right word.
        push_st(32'h5A5A0001);
        repeat (3) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_rd_en", 96'(st_if.fifo_rd_en), 96'd0);
        end
        push_st(32'h5A5A0002);
        #1;
        chk("stall_resume_rd_en", 96'(st_if.fifo_rd_en), 96'd1);
        tick();
        chk("stall_wait_valid", 96'(st_if.sample_valid), 96'd0);
        tick();
        chk("stall_present", 96'(st_if.sample_valid), 96'd1);
        chk("stall_frame", {st_if.sample_left, st_if.sample_right}, {32'h5A5A0001, 32'h5A5A0002});
        st_if.sample_ready = 1'b1;
        tick();
        st_if.sample_ready = 1'b0;

        // Overrun drop, then the handshake beating a simultaneous almost-full.
        push_st(32'hF1000001);
        push_st(32'hF1000002);
        push_st(32'hF2000001);
        push_st(32'hF2000002);
        wait_valid("ovr_first_present");
        st_if.fifo_almost_full = 1'b1;
        tick();
        st_if.fifo_almost_full = 1'b0;
        chk("ovr_valid_dropped", 96'(st_if.sample_valid), 96'd0);
        chk("ovr_cnt_one", 96'(st_if.overrun_cnt), 96'd1);
        wait_valid("ovr_next_present");
        chk("ovr_next_frame", {st_if.sample_left, st_if.sample_right}, {32'hF2000001, 32'hF2000002});
        st_if.fifo_almost_full = 1'b1;
        st_if.sample_ready     = 1'b1;
        tick();
        st_if.fifo_almost_full = 1'b0;
        st_if.sample_ready     = 1'b0;
        chk("hs_wins_valid", 96'(st_if.sample_valid), 96'd0);
        chk("hs_wins_cnt", 96'(st_if.overrun_cnt), 96'd1);

        // Underrun: sticky, cleared by clr_status, event beats a coincident clear.
        tick();
        chk("unr_before", 96'(st_if.underrun), 96'd0);
        st_if.sample_ready = 1'b1;
        tick();
        st_if.sample_ready = 1'b0;
        chk("unr_set", 96'(st_if.underrun), 96'd1);
        repeat (2) tick();
        chk("unr_sticky", 96'(st_if.underrun), 96'd1);
        st_if.clr_status = 1'b1;
        tick();
        st_if.clr_status = 1'b0;
        chk("unr_cleared", 96'(st_if.underrun), 96'd0);
        chk("ovr_cleared", 96'(st_if.overrun_cnt), 96'd0);
        st_if.clr_status   = 1'b1;
        st_if.sample_ready = 1'b1;
        tick();
        st_if.clr_status   = 1'b0;
        st_if.sample_ready = 1'b0;
        chk("unr_beats_clear", 96'(st_if.underrun), 96'd1);

        // Reset in WAIT_R discards the partial frame; next word is left again.
        push_st(32'h0BAD0001);
        push_st(32'h0BAD0002);
        repeat (4) tick();
        chk("pre_reset_valid", 96'(st_if.sample_valid), 96'd0);
        resetn = 1'b0;
        #1;
        chk("reset_immediate",
            {st_if.fifo_rd_en, st_if.sample_valid, st_if.underrun, st_if.overrun_cnt,
             st_if.sample_left, st_if.sample_right}, 96'd0);
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        push_st(32'hCAFE0001);
        push_st(32'hCAFE0002);
        st_if.sample_ready = 1'b1;
        wait_valid("post_reset_present");
        chk("post_reset_frame", {st_if.sample_left, st_if.sample_right}, {32'hCAFE0001, 32'hCAFE0002});
        tick();
        st_if.sample_ready = 1'b0;
        tick();
        chk("scoreboard_drained", 96'(exp_frames.size()), 96'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_fifo_rd_ctrl.md
Name: adc_fifo_rd_ctrl

Overview:
- Read-side sequencer for the ADC input dual-clock FIFO, in the alg_clk domain.
- Pops 32-bit I2S words from the FIFO and drives the FIFO RdEn, replacing the free-running send_next_sample strobe.
- Assembles the words into left/right frames and presents each frame to the effects algorithm with a valid/ready handshake.
- Detects and counts overrun (FIFO near full while the algorithm stalls) and underrun (algorithm ready with no data).

Parameters:
RD_LATENCY, 1, alg_clk cycles from fifo_rd_en high to fifo_q valid; legal range 1..3.
STEREO, 1'b1, 1 = two words per frame (left, then right); 0 = one word per frame, copied to both channels.
DROP_ON_FULL, 1'b1, 1 = discard the held frame when FIFO is almost full and the consumer stalls.

Ports:
alg_clk  input  1  algorithm clock; all logic is on its rising edge.
resetn  input  1  asynchronous active-low reset.
fifo_empty  input  1  FIFO Empty flag.
fifo_almost_full  input  1  FIFO AlmostFull flag.
fifo_q  input  32  FIFO read data.
fifo_rd_en  output  1  FIFO RdEn.
sample_ready  input  1  algorithm accepts the frame.
sample_valid  output  1  frame held on sample_left/sample_right.
sample_left  output  32  left-channel word.
sample_right  output  32  right-channel word.
overrun_cnt  output  16  saturating count of dropped frames.
underrun  output  1  sticky underrun flag.
clr_status  input  1  synchronous clear of overrun_cnt and underrun.

Behaviour:
- Reset (asynchronous assert, synchronous release on alg_clk):
  - state = IDLE.
  - fifo_rd_en, sample_valid and underrun are 0.
  - sample_left, sample_right and overrun_cnt are 0.
  - Reset mid-frame discards any partial frame. No FIFO read is issued until reset is released.
- States: IDLE, RD_L, WAIT_L, RD_R, WAIT_R, PRESENT.
  - IDLE: if !fifo_empty, go to RD_L; else stay.
  - RD_L: fifo_rd_en = 1 for exactly this cycle (entered only when non-empty). Go to WAIT_L.
  - WAIT_L: hold RD_LATENCY cycles. On the last cycle, register fifo_q into sample_left. Then go to RD_R if STEREO; else copy the word to sample_right as well and go to PRESENT.
  - RD_R: fifo_rd_en = !fifo_empty. While empty, stay and issue no read. When the read issues, go to WAIT_R.
  - WAIT_R: hold RD_LATENCY cycles, register fifo_q into sample_right on the last one, then go to PRESENT.
  - PRESENT: sample_valid = 1, outputs stable. If sample_ready, the handshake completes this cycle; next state is IDLE and valid falls next cycle.
- fifo_rd_en is high only in RD_L and RD_R; it is never asserted while fifo_empty = 1.
- Latency, RD_LATENCY = 1, non-empty FIFO, counted from the first IDLE cycle that sees !fifo_empty (cycle 0):
  - Stereo: rd_en in cycles 1 and 3; sample_valid from cycle 5.
  - Mono: rd_en in cycle 1; sample_valid from cycle 3.
  - Back-to-back frames have at most one IDLE cycle between handshakes.
- Overrun:
  - Condition: state PRESENT, fifo_almost_full = 1, sample_ready = 0, DROP_ON_FULL = 1.
  - Action: the held frame is discarded, sample_valid drops next cycle, state goes to IDLE, overrun_cnt increments (saturates at 16'hFFFF).
  - This is the only case where valid is withdrawn without a handshake.
  - Simultaneous sample_ready = 1 in the same cycle: the handshake wins and nothing is dropped.
  - DROP_ON_FULL = 0: PRESENT holds indefinitely and the FIFO may overflow.
- Underrun: set when state IDLE, fifo_empty = 1 and sample_ready = 1; stays set until clr_status.
- clr_status:
  - Zeroes overrun_cnt and underrun next cycle.
  - If an overrun or underrun event occurs in the same cycle as clr_status, the event wins: count = 1 / flag = 1.
- Stereo alignment: the first word after reset is left. The channel order is never resynchronised except by reset.

Test Plan:
- Reset, then preload FIFO with 32'hAAAA0001, 32'hBBBB0002; sample_ready = 1. Expect fifo_rd_en in cycles 1 and 3; sample_valid in cycle 5 with left = AAAA0001, right = BBBB0002; one-cycle valid.
- STEREO = 0, one word 32'h12345678. Expect valid in cycle 3 with left = right = 12345678.
- Left word only, then fifo_empty held 10 cycles. Expect FSM stalls in RD_R with fifo_rd_en = 0 throughout; completes 2 cycles (RD_R + WAIT_R) after the right word arrives.
- sample_ready = 0 with fifo_almost_full raised in PRESENT. Expect valid drops next cycle, overrun_cnt = 1, next frame presented. Repeat with ready = 1 in the same cycle: no drop, count unchanged.
- Empty FIFO with sample_ready = 1. Expect underrun = 1 sticky; clr_status pulse clears it; clr_status coincident with a new underrun leaves it 1.
- Assert resetn = 0 in WAIT_R. Expect all outputs 0 immediately; after release, the next word is treated as left.
